alu_mul_seq: RTL and testbench

Multi-cycle multiply sequencer for the shared 16-bit datapath ALU in the multi-cycle MIPS core. It accepts a start request and drives the external ALU's operand and control inputs one add per cycle, using shift-and-add to form the low 16 bits of A×B. Shifting and iteration counting happen locally; all additions go through the shared ALU. It sits beside the main control FSM, which hands the ALU ports to this block while `busy` is high.

---
 rtl/alu_pkg.sv | 20 ++
 rtl/alu.sv | 30 +++
 rtl/alu_mul_seq.sv | 107 ++++++++++
 tb/tb_alu_mul_seq.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the datapath ALU and the multiply sequencer.
//   ALU_* : 3-bit ALU control codes
//   seq_state_t : multiply sequencer state encoding
package alu_pkg;

  localparam logic [2:0] ALU_AND    = 3'd0;
  localparam logic [2:0] ALU_OR     = 3'd1;
  localparam logic [2:0] ALU_ADD    = 3'd2;
  localparam logic [2:0] ALU_SUB    = 3'd3;
  localparam logic [2:0] ALU_NOT    = 3'd4;
  localparam logic [2:0] ALU_PASS_A = 3'd5;
  localparam logic [2:0] ALU_PASS_B = 3'd6;

  typedef enum logic [1:0] {
    SEQ_IDLE = 2'd0,
    SEQ_RUN  = 2'd1,
    SEQ_DONE = 2'd2
  } seq_state_t;

endpackage

// File: rtl/alu.sv
// Shared combinational datapath ALU.
//   i_a, i_b : operands
//   i_ctrl   : operation select (alu_pkg::ALU_*)
//   o_y      : result, combinational
module alu
  import alu_pkg::*;
#(
  parameter int W = 16
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic [2:0]   i_ctrl,
  output logic [W-1:0] o_y
);

  always_comb begin
    o_y = '0;
    case (i_ctrl)
      ALU_AND:    o_y = i_a & i_b;
      ALU_OR:     o_y = i_a | i_b;
      ALU_ADD:    o_y = i_a + i_b;
      ALU_SUB:    o_y = i_a - i_b;
      ALU_NOT:    o_y = ~i_a;
      ALU_PASS_A: o_y = i_a;
      ALU_PASS_B: o_y = i_b;
      default:    o_y = '0;
    endcase
  end

endmodule

// File: rtl/alu_mul_seq.sv
// Multi-cycle shift-and-add multiply sequencer driving the shared ALU.
// Forms the low W bits of a*b; every addition goes through the external ALU.
//
//   state | meaning
//   IDLE  | waiting for start, ALU parked on pass-A of zero
//   RUN   | one partial-product add (or skip) per cycle
//   DONE  | product valid, done pulse, back to IDLE
//
//   clk, rst_n            : clock, async active-low reset
//   start, a, b           : request and operands (latched on acceptance)
//   busy, done, product   : status and low-W result
//   alu_a, alu_b, alu_ctrl: drive to the shared ALU
//   alu_y                 : ALU result
module alu_mul_seq
  import alu_pkg::*;
#(
  parameter int W     = 16,
  parameter int CNT_W = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] product,
  output logic [W-1:0] alu_a,
  output logic [W-1:0] alu_b,
  output logic [2:0]   alu_ctrl,
  input  logic [W-1:0] alu_y
);

  seq_state_t       r_state, w_state_next;
  logic [W-1:0]     r_acc, w_acc_next;
  logic [W-1:0]     r_mcand, w_mcand_next;
  logic [W-1:0]     r_mplier, w_mplier_next;
  logic [CNT_W-1:0] r_cnt, w_cnt_next;
  logic [W-1:0]     r_product;

  // ALU drive kept in its own process so the alu_y feedback path is clearly acyclic.
  always_comb begin
    alu_a    = '0;
    alu_b    = '0;
    alu_ctrl = ALU_PASS_A;
    if (r_state == SEQ_RUN) begin
      alu_a    = r_acc;
      alu_b    = r_mcand;
      alu_ctrl = r_mplier[0] ? ALU_ADD : ALU_PASS_A;
    end
  end

  always_comb begin
    w_state_next  = r_state;
    w_acc_next    = r_acc;
    w_mcand_next  = r_mcand;
    w_mplier_next = r_mplier;
    w_cnt_next    = r_cnt;
    case (r_state)
      SEQ_IDLE: begin
        if (start) begin
          w_acc_next    = '0;
          w_mcand_next  = a;
          w_mplier_next = b;
          w_cnt_next    = '0;
          w_state_next  = (b == '0) ? SEQ_DONE : SEQ_RUN;
        end
      end
      SEQ_RUN: begin
        if (r_mplier[0]) w_acc_next = alu_y;
        w_mcand_next  = r_mcand << 1;
        w_mplier_next = r_mplier >> 1;
        w_cnt_next    = r_cnt + CNT_W'(1);
        // Stop early once no multiplier bits remain.
        if ((r_mplier >> 1) == '0 || r_cnt == CNT_W'(W - 1))
          w_state_next = SEQ_DONE;
      end
      SEQ_DONE: w_state_next = SEQ_IDLE;
      default:  w_state_next = SEQ_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= SEQ_IDLE;
      r_acc     <= '0;
      r_mcand   <= '0;
      r_mplier  <= '0;
      r_cnt     <= '0;
      r_product <= '0;
    end else begin
      r_state  <= w_state_next;
      r_acc    <= w_acc_next;
      r_mcand  <= w_mcand_next;
      r_mplier <= w_mplier_next;
      r_cnt    <= w_cnt_next;
      // Capture on entry to DONE so product is valid in the same cycle as done.
      if (w_state_next == SEQ_DONE && r_state != SEQ_DONE)
        r_product <= w_acc_next;
    end
  end

  assign busy    = (r_state != SEQ_IDLE);
  assign done    = (r_state == SEQ_DONE);
  assign product = r_product;

endmodule

// File: tb/tb_alu_mul_seq.sv
module tb_alu_mul_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] a, b;
  logic        busy, done;
  logic [15:0] product;
  logic [15:0] w_alu_a, w_alu_b, w_alu_y;
  logic [2:0]  w_alu_ctrl;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [15:0] last_prod = 16'h0;

  typedef struct {
    logic [15:0] prod;
    int          lat;
    int          t0;
  } exp_t;
  exp_t q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alu #(.W(16)) u_alu (
    .i_a(w_alu_a), .i_b(w_alu_b), .i_ctrl(w_alu_ctrl), .o_y(w_alu_y)
  );

  alu_mul_seq #(.W(16), .CNT_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .product(product),
    .alu_a(w_alu_a), .alu_b(w_alu_b), .alu_ctrl(w_alu_ctrl), .alu_y(w_alu_y)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] ref_prod(input logic [15:0] x, input logic [15:0] y);
    logic [31:0] full;
    full = {16'h0, x} * {16'h0, y};
    return full[15:0];
  endfunction

  // Cycles from acceptance to the done cycle: one per significant multiplier bit plus one.
  function automatic int ref_lat(input logic [15:0] y);
    int k = 0;
    for (int i = 0; i < 16; i++) if (y[i]) k = i + 1;
    return k + 1;
  endfunction

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (rst_n) begin
      if (done) begin
        if (q.size() == 0) begin
          chk("unexpected_done", 32'(done), 32'd0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("product", 32'(product), 32'(e.prod));
          chk("latency", 32'(cyc - e.t0), 32'(e.lat));
          chk("busy_in_done", 32'(busy), 32'd1);
          chk("ctrl_in_done", 32'(w_alu_ctrl), 32'd5);
          last_prod = e.prod;
        end
      end else if (!busy) begin
        chk("idle_alu_ctrl", 32'(w_alu_ctrl), 32'd5);
        chk("idle_alu_ab", {w_alu_a, w_alu_b}, 32'd0);
        chk("product_hold", 32'(product), 32'(last_prod));
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (busy) chk("wait_idle_timeout", 32'(busy), 32'd0);
  endtask

  task automatic issue(input logic [15:0] ia, input logic [15:0] ib);
    exp_t e;
    wait_idle();
    a = ia;
    b = ib;
    start = 1'b1;
    e.prod = ref_prod(ia, ib);
    e.lat  = ref_lat(ib);
    e.t0   = cyc;
    q.push_back(e);
    @(negedge clk);
    start = 1'b0;
    a = 16'($urandom);
    b = 16'($urandom);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    a = '0;
    b = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_product", 32'(product), 32'd0);
    chk("rst_alu_ab", {w_alu_a, w_alu_b}, 32'd0);
    chk("rst_alu_ctrl", 32'(w_alu_ctrl), 32'd5);
    rst_n = 1'b1;
    @(negedge clk);

    issue(16'd3, 16'd5);
    issue(16'hFFFE, 16'd7);
    issue(16'h1234, 16'h0000);
    issue(16'h0100, 16'h8000);

    // Request while busy must be ignored.
    issue(16'd6, 16'd9);
    @(negedge clk);
    a = 16'd1;
    b = 16'd1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    issue(16'd7, 16'd3);

    // Request during the DONE cycle must be ignored.
    issue(16'd2, 16'd1);
    begin
      int n = 0;
      while (!done && n < 50) begin
        @(negedge clk);
        n++;
      end
      chk("reach_done", 32'(done), 32'd1);
    end
    a = 16'd9;
    b = 16'd9;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #1;
    chk("start_in_done_ignored", 32'(busy), 32'd0);
    @(negedge clk);

    // Reset mid-operation.
    issue(16'd5, 16'hFFFF);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_product", 32'(product), 32'd0);
    q.delete();
    last_prod = 16'h0;
    @(negedge clk);
    rst_n = 1'b1;
    issue(16'd4, 16'd4);

    for (int i = 0; i < 30; i++) begin
      logic [15:0] ra, rb;
      ra = 16'($urandom);
      rb = 16'($urandom) >> $urandom_range(0, 15);
      issue(ra, rb);
    end

    begin
      int n = 0;
      while (q.size() != 0 && n < 100) begin
        @(negedge clk);
        n++;
      end
      chk("queue_drained", 32'(q.size()), 32'd0);
    end
    repeat (2) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
